// File: rtl/ts_pkg.sv
// rtl/ts_pkg.sv - shared constants and FSM state types for the TS packet buffer
package ts_pkg;

  localparam int         PKT_LEN_C    = 188;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         SLOT_OFS_W   = 8;

  typedef enum logic [1:0] {
    WR_HUNT = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ts_pkt_ram.sv
// rtl/ts_pkt_ram.sv - simple dual-port packet RAM, 256 bytes per slot, registered read
import ts_pkg::*;

module ts_pkt_ram #(
  parameter int DEPTH_PKTS = 4,
  parameter int AW         = $clog2(DEPTH_PKTS) + SLOT_OFS_W
) (
  input  logic          SYS_CLK,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH_PKTS * (1 << SLOT_OFS_W)];

  always_ff @(posedge SYS_CLK) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/ts_packet_buffer.sv
// rtl/ts_packet_buffer.sv - per-tuner TS packet store with one-packet replay on request
// Optional TS_SYNC_CHECK_EN: a packet start also requires DATA_IN to be the 0x47 sync byte.
import ts_pkg::*;

module ts_packet_buffer #(
  parameter int PKT_LEN    = PKT_LEN_C,
  parameter int DEPTH_PKTS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                        SYS_CLK,
  input  logic                        RST,
  input  logic                        D_VALID_IN,
  input  logic                        P_SYNC_IN,
  input  logic [7:0]                  DATA_IN,
  input  logic                        GIVE_ME_ONE_PACKET,
  output logic                        GOT_FULL_PACKET,
  output logic [7:0]                  DATA_OUT,
  output logic                        RD_ACTIVE,
  output logic [$clog2(DEPTH_PKTS):0] PKT_COUNT,
  output logic [CNT_W-1:0]            OVERFLOW_CNT
);

  localparam int SLOT_W = $clog2(DEPTH_PKTS);
  localparam int CW     = SLOT_W + 1;
  localparam int OW     = CW + 1;
  localparam int AW     = SLOT_W + SLOT_OFS_W;
  localparam logic [SLOT_OFS_W-1:0] LAST_OFS = SLOT_OFS_W'(PKT_LEN - 1);
  localparam logic [SLOT_OFS_W-1:0] IDLE_LIM = SLOT_OFS_W'(PKT_LEN);

  wr_state_e             wr_state_q, wr_state_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic [SLOT_W-1:0]     wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [SLOT_OFS_W-1:0] wr_ofs_q, wr_ofs_d, rd_ofs_q, rd_ofs_d, idle_cnt_q, idle_cnt_d;
  logic [CW-1:0]         pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0]      ovf_q, ovf_d;
  logic                  got_full_q, got_full_d, ram_vld_q, ram_vld_d, rd_active_q, rd_active_d;
  logic [7:0]            data_out_q, data_out_d;

  logic          is_start, bad_sync, has_room, take_start, commit, accept, ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [7:0]    ram_rdata;
  logic [OW-1:0] occupied;

`ifdef TS_SYNC_CHECK_EN
  assign is_start = P_SYNC_IN && (DATA_IN == TS_SYNC_BYTE);
  assign bad_sync = P_SYNC_IN && (DATA_IN != TS_SYNC_BYTE);
`else
  assign is_start = P_SYNC_IN;
  assign bad_sync = 1'b0;
`endif

  // The read FSM is busy from acceptance to drain, which protects the slot before RD_ACTIVE rises.
  assign occupied = {1'b0, pkt_count_q} + OW'(rd_state_q != RD_IDLE);
  assign has_room = occupied < OW'(DEPTH_PKTS);
  assign accept   = (rd_state_q == RD_IDLE) && GIVE_ME_ONE_PACKET && (pkt_count_q != '0);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_slot_d  = wr_slot_q;
    wr_ofs_d   = wr_ofs_q;
    idle_cnt_d = idle_cnt_q;
    ovf_d      = ovf_q;
    ram_we     = 1'b0;
    ram_waddr  = {wr_slot_q, wr_ofs_q};
    commit     = 1'b0;
    take_start = 1'b0;
    if (D_VALID_IN) begin
      idle_cnt_d = '0;
      case (wr_state_q)
        WR_FILL: begin
          if (is_start) begin
            take_start = 1'b1;
          end else if (bad_sync) begin
            wr_state_d = WR_HUNT;
          end else begin
            ram_we = 1'b1;
            if (wr_ofs_q == LAST_OFS) begin
              commit     = 1'b1;
              wr_slot_d  = wr_slot_q + 1'b1;
              wr_state_d = WR_HUNT;
            end else begin
              wr_ofs_d = wr_ofs_q + 1'b1;
            end
          end
        end
        default: take_start = is_start;
      endcase
      if (take_start) begin
        if (has_room) begin
          ram_we     = 1'b1;
          ram_waddr  = {wr_slot_q, {SLOT_OFS_W{1'b0}}};
          wr_ofs_d   = SLOT_OFS_W'(1);
          wr_state_d = WR_FILL;
        end else begin
          wr_state_d = WR_DROP;
          if (ovf_q != '1) ovf_d = ovf_q + 1'b1;
        end
      end
    end else if (wr_state_q == WR_FILL) begin
      if (idle_cnt_q >= IDLE_LIM) begin
        wr_state_d = WR_HUNT;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  // Two drain cycles let the RAM and output registers empty before a new request is taken.
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_ofs_d    = rd_ofs_q;
    rd_slot_d   = rd_slot_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (accept) begin
          rd_state_d = RD_READ;
          rd_ofs_d   = '0;
        end
      end
      RD_READ: begin
        if (rd_ofs_q == LAST_OFS) begin
          rd_state_d = RD_DRAIN;
          rd_ofs_d   = '0;
        end else begin
          rd_ofs_d = rd_ofs_q + 1'b1;
        end
      end
      RD_DRAIN: begin
        if (rd_ofs_q == SLOT_OFS_W'(1)) begin
          rd_state_d = RD_IDLE;
          rd_slot_d  = rd_slot_q + 1'b1;
        end else begin
          rd_ofs_d = rd_ofs_q + 1'b1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    ram_raddr   = {rd_slot_q, rd_ofs_q};
    ram_vld_d   = (rd_state_q == RD_READ);
    rd_active_d = ram_vld_q;
    data_out_d  = ram_vld_q ? ram_rdata : 8'h00;
    pkt_count_d = pkt_count_q + CW'(commit) - CW'(accept);
    got_full_d  = (pkt_count_d != '0);
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      wr_state_q  <= WR_HUNT;
      rd_state_q  <= RD_IDLE;
      wr_slot_q   <= '0;
      rd_slot_q   <= '0;
      wr_ofs_q    <= '0;
      rd_ofs_q    <= '0;
      idle_cnt_q  <= '0;
      pkt_count_q <= '0;
      ovf_q       <= '0;
      got_full_q  <= 1'b0;
      ram_vld_q   <= 1'b0;
      rd_active_q <= 1'b0;
      data_out_q  <= 8'h00;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      wr_slot_q   <= wr_slot_d;
      rd_slot_q   <= rd_slot_d;
      wr_ofs_q    <= wr_ofs_d;
      rd_ofs_q    <= rd_ofs_d;
      idle_cnt_q  <= idle_cnt_d;
      pkt_count_q <= pkt_count_d;
      ovf_q       <= ovf_d;
      got_full_q  <= got_full_d;
      ram_vld_q   <= ram_vld_d;
      rd_active_q <= rd_active_d;
      data_out_q  <= data_out_d;
    end
  end

  ts_pkt_ram #(.DEPTH_PKTS(DEPTH_PKTS), .AW(AW)) u_ram (
    .SYS_CLK (SYS_CLK),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (DATA_IN),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  assign GOT_FULL_PACKET = got_full_q;
  assign DATA_OUT        = data_out_q;
  assign RD_ACTIVE       = rd_active_q;
  assign PKT_COUNT       = pkt_count_q;
  assign OVERFLOW_CNT    = ovf_q;

endmodule
